fb_pattern_writer: RTL and testbench

Wishbone master that fills the SDRAM frame buffer with a test pattern, one 32-bit word per pixel. The vga scanout engine reads this same buffer at `BASE_ADR + 4*(HDISP*y + x)`; this block is the writer for that layout. It shares the SDRAM Wishbone bus through the bus arbiter and releases `cyc` periodically so scanout never starves.

---
 rtl/fb_pkg.sv | 30 +++
 rtl/fb_pattern_gen.sv | 37 +++
 rtl/fb_pattern_writer.sv | 203 ++++++++++++++++++++
 tb/tb_fb_pattern_writer.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Shared types and constants for the frame-buffer pattern writer.
//   pattern_e : test pattern selector encoding
//   state_e   : writer FSM states
//   rgb_t     : 24-bit {R,G,B} pixel colour
//   BAR_LUT   : colour-bar palette, index 0 = leftmost bar
package fb_pkg;

  typedef logic [23:0] rgb_t;

  typedef enum logic [1:0] {
    PAT_GRID  = 2'd0,
    PAT_BARS  = 2'd1,
    PAT_SOLID = 2'd2,
    PAT_GRAD  = 2'd3
  } pattern_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WRITE   = 2'd1,
    ST_RELEASE = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  // white, yellow, cyan, green, magenta, red, blue, black
  localparam rgb_t BAR_LUT [8] = '{
    24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
    24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
  };

endpackage

// File: rtl/fb_pattern_gen.sv
// Combinational pixel colour generator.
//   pattern_i : selected test pattern
//   solid_i   : colour used by the solid pattern
//   x_i, y_i  : pixel position
//   bar_i     : colour-bar index of column x_i (tracked by the caller)
//   rgb_c_o   : resulting 24-bit colour
module fb_pattern_gen
  import fb_pkg::*;
#(
  parameter int unsigned XW = 10,
  parameter int unsigned YW = 9
) (
  input  pattern_e        pattern_i,
  input  rgb_t            solid_i,
  input  logic [XW-1:0]   x_i,
  input  logic [YW-1:0]   y_i,
  input  logic [2:0]      bar_i,
  output rgb_t            rgb_c_o
);

  logic grid_line;

  // Grid line on every 16th column or row; masking the low bits avoids a modulo.
  assign grid_line = ((x_i & XW'(15)) == '0) || ((y_i & YW'(15)) == '0);

  always_comb begin
    rgb_c_o = 24'h000000;
    case (pattern_i)
      PAT_GRID:  rgb_c_o = grid_line ? 24'hFFFFFF : 24'h000000;
      PAT_BARS:  rgb_c_o = BAR_LUT[bar_i];
      PAT_SOLID: rgb_c_o = solid_i;
      PAT_GRAD:  rgb_c_o = {8'(x_i), 8'(y_i), 8'h80};
      default:   rgb_c_o = 24'h000000;
    endcase
  end

endmodule

// File: rtl/fb_pattern_writer.sv
// Wishbone master that fills the frame buffer with a test pattern, one
// 32-bit word per pixel at BASE_ADR + 4*(HDISP*y + x). The bus is released
// for one cycle after every BURST acknowledged writes.
//   wshb_clk, wshb_rst_n     : clock, async active-low reset
//   start, continuous        : frame request / auto-restart at end of frame
//   pattern_sel, solid_rgb   : pattern selection, latched at frame start
//   busy, frame_done         : status
//   wshb_*                   : Wishbone master write port
module fb_pattern_writer
  import fb_pkg::*;
#(
  parameter int unsigned HDISP    = 800,
  parameter int unsigned VDISP    = 480,
  parameter int unsigned BURST    = 64,
  parameter logic [31:0] BASE_ADR = 32'h0
) (
  input  logic        wshb_clk,
  input  logic        wshb_rst_n,
  input  logic        start,
  input  logic        continuous,
  input  logic [1:0]  pattern_sel,
  input  logic [23:0] solid_rgb,
  output logic        busy,
  output logic        frame_done,
  output logic [31:0] wshb_adr,
  output logic [31:0] wshb_dat_ms,
  output logic        wshb_we,
  output logic [3:0]  wshb_sel,
  output logic [2:0]  wshb_cti,
  output logic [1:0]  wshb_bte,
  output logic        wshb_stb,
  output logic        wshb_cyc,
  input  logic        wshb_ack,
  input  logic        wshb_err
);

  localparam int unsigned XW      = (HDISP > 1) ? $clog2(HDISP) : 1;
  localparam int unsigned YW      = (VDISP > 1) ? $clog2(VDISP) : 1;
  localparam int unsigned BAR_LEN = HDISP / 8;
  localparam int unsigned BCW     = (BAR_LEN > 1) ? $clog2(BAR_LEN) : 1;
  localparam int unsigned CW      = (BURST > 1) ? $clog2(BURST) : 1;

  state_e          state_q, state_d;
  pattern_e        pat_q, pat_d;
  rgb_t            solid_q, solid_d;
  logic [XW-1:0]   x_q, x_d;
  logic [YW-1:0]   y_q, y_d;
  logic [2:0]      bar_q, bar_d;
  logic [BCW-1:0]  bx_q, bx_d;
  logic [CW-1:0]   burst_q, burst_d;
  logic [31:0]     adr_q, adr_d;
  logic [31:0]     dat_q;
  logic            stb_q, stb_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            load_c;
  logic            adv_c;
  logic            last_px_c;
  logic            x_end_c;
  rgb_t            rgb_c;

  assign x_end_c   = (x_q == XW'(HDISP - 1));
  assign last_px_c = x_end_c && (y_q == YW'(VDISP - 1));

  // Next-state, counters and address; load_c starts a frame from IDLE or DONE.
  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    solid_d = solid_q;
    x_d     = x_q;
    y_d     = y_q;
    bar_d   = bar_q;
    bx_d    = bx_q;
    burst_d = burst_q;
    adr_d   = adr_q;
    load_c  = 1'b0;
    adv_c   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) load_c = 1'b1;
      end
      ST_WRITE: begin
        if (wshb_ack) begin
          adv_c = 1'b1;
          adr_d = adr_q + 32'd4;
          if (last_px_c) begin
            state_d = ST_DONE;
            x_d     = '0;
            y_d     = '0;
            bar_d   = '0;
            bx_d    = '0;
          end else begin
            if (x_end_c) begin
              x_d   = '0;
              y_d   = y_q + 1'b1;
              bar_d = '0;
              bx_d  = '0;
            end else begin
              x_d = x_q + 1'b1;
              if (bx_q == BCW'(BAR_LEN - 1)) begin
                bx_d  = '0;
                bar_d = bar_q + 3'd1;
              end else begin
                bx_d = bx_q + 1'b1;
              end
            end
            if (burst_q == CW'(BURST - 1)) begin
              state_d = ST_RELEASE;
              burst_d = '0;
            end else begin
              burst_d = burst_q + 1'b1;
            end
          end
        end else if (wshb_err) begin
          // Errored beat: hold everything so the same write is reissued.
          state_d = ST_WRITE;
        end
      end
      ST_RELEASE: state_d = ST_WRITE;
      ST_DONE: begin
        if (continuous) load_c = 1'b1;
        else            state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (load_c) begin
      state_d = ST_WRITE;
      pat_d   = pattern_e'(pattern_sel);
      solid_d = solid_rgb;
      x_d     = '0;
      y_d     = '0;
      bar_d   = '0;
      bx_d    = '0;
      burst_d = '0;
      adr_d   = BASE_ADR;
      adv_c   = 1'b1;
    end

    stb_d  = (state_d == ST_WRITE);
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  // Colour is computed from the next pixel position so it lines up with adr.
  fb_pattern_gen #(
    .XW(XW),
    .YW(YW)
  ) u_gen (
    .pattern_i (pat_d),
    .solid_i   (solid_d),
    .x_i       (x_d),
    .y_i       (y_d),
    .bar_i     (bar_d),
    .rgb_c_o   (rgb_c)
  );

  // State and bus registers.
  always_ff @(posedge wshb_clk or negedge wshb_rst_n) begin
    if (!wshb_rst_n) begin
      state_q <= ST_IDLE;
      pat_q   <= PAT_GRID;
      solid_q <= '0;
      x_q     <= '0;
      y_q     <= '0;
      bar_q   <= '0;
      bx_q    <= '0;
      burst_q <= '0;
      adr_q   <= '0;
      dat_q   <= '0;
      stb_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      solid_q <= solid_d;
      x_q     <= x_d;
      y_q     <= y_d;
      bar_q   <= bar_d;
      bx_q    <= bx_d;
      burst_q <= burst_d;
      adr_q   <= adr_d;
      if (adv_c) dat_q <= {8'h00, rgb_c};
      stb_q   <= stb_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy        = busy_q;
  assign frame_done  = done_q;
  assign wshb_adr    = adr_q;
  assign wshb_dat_ms = dat_q;
  assign wshb_stb    = stb_q;
  assign wshb_cyc    = stb_q;
  assign wshb_we     = 1'b1;
  assign wshb_sel    = 4'hF;
  assign wshb_cti    = 3'd0;
  assign wshb_bte    = 2'd0;

endmodule

// File: tb/tb_fb_pattern_writer.sv
// Scoreboard bench for fb_pattern_writer (16x4 frame, burst 8, base 0x100).
module tb_fb_pattern_writer;

  localparam int unsigned HD   = 16;
  localparam int unsigned VD   = 4;
  localparam int unsigned BU   = 8;
  localparam logic [31:0] BASE = 32'h100;
  localparam int unsigned NPIX = HD * VD;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, continuous;
  logic [1:0]  pattern_sel;
  logic [23:0] solid_rgb;
  logic        busy, frame_done;
  logic [31:0] adr, dat;
  logic        we, stb, cyc;
  logic [3:0]  sel;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic        ack = 1'b0, err = 1'b0;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [63:0] sb_q[$];
  int          ack_mode = 0;   // 0 tied high, 1 zero-wait, 2 random 0..3 wait
  bit          err_arm  = 1'b0;
  localparam logic [31:0] ERR_ADR = 32'h114;

  always #5 clk = ~clk;

  fb_pattern_writer #(
    .HDISP(HD), .VDISP(VD), .BURST(BU), .BASE_ADR(BASE)
  ) dut (
    .wshb_clk(clk), .wshb_rst_n(rst_n), .start(start), .continuous(continuous),
    .pattern_sel(pattern_sel), .solid_rgb(solid_rgb), .busy(busy),
    .frame_done(frame_done), .wshb_adr(adr), .wshb_dat_ms(dat), .wshb_we(we),
    .wshb_sel(sel), .wshb_cti(cti), .wshb_bte(bte), .wshb_stb(stb),
    .wshb_cyc(cyc), .wshb_ack(ack), .wshb_err(err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model(input int p, input logic [23:0] s,
                                        input int x, input int y);
    logic [23:0] bars [8];
    logic [7:0]  xb, yb;
    bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
             24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    xb = 8'(x);
    yb = 8'(y);
    case (p)
      0:       return ((x % 16 == 0) || (y % 16 == 0)) ? 32'h00FFFFFF : 32'h0;
      1:       return {8'h00, bars[x / (HD / 8)]};
      2:       return {8'h00, s};
      default: return {8'h00, xb, yb, 8'h80};
    endcase
  endfunction

  task automatic push_frame(input int p, input logic [23:0] s);
    for (int y = 0; y < VD; y++)
      for (int x = 0; x < HD; x++)
        sb_q.push_back({BASE + 32'(4 * (HD * y + x)), model(p, s, x, y)});
  endtask

  // Slave model: drives ack/err for the coming edge.
  int wcnt = 0;
  always @(negedge clk) begin
    ack = 1'b0;
    err = 1'b0;
    if (!rst_n) begin
      wcnt = 0;
      if (ack_mode == 0) ack = 1'b1;
    end else if (ack_mode == 0) begin
      ack = 1'b1;
    end else if (stb) begin
      if (err_arm && adr == ERR_ADR) begin
        err     = 1'b1;
        err_arm = 1'b0;
      end else if (wcnt == 0) begin
        ack  = 1'b1;
        wcnt = (ack_mode == 2) ? int'($urandom_range(0, 3)) : 0;
      end else begin
        wcnt--;
      end
    end
  end

  // Monitor: pops expected beats on every accepted write, checks hold
  // stability during waits and the release/done cycle structure.
  int          ack_k    = 0;
  int          expect_s = 0;   // 1 stb, 2 release, 3 done, 4 resume, 5 idle
  bit          hold_v   = 1'b0;
  logic [31:0] hold_adr, hold_dat;
  logic [63:0] e;
  always @(negedge clk) begin
    #1;
    if (!rst_n) begin
      ack_k    = 0;
      expect_s = 0;
      hold_v   = 1'b0;
    end else begin
      case (expect_s)
        1: chk("stb_after_ack", 32'(stb), 32'd1);
        2: begin chk("release_cyc", 32'(cyc), 32'd0); chk("release_done", 32'(frame_done), 32'd0); end
        3: begin chk("done_pulse", 32'(frame_done), 32'd1); chk("done_stb", 32'(stb), 32'd0); end
        4: begin chk("resume_stb", 32'(stb), 32'd1); chk("resume_done", 32'(frame_done), 32'd0); end
        5: begin chk("idle_busy", 32'(busy), 32'd0); chk("idle_done", 32'(frame_done), 32'd0); end
        default: ;
      endcase
      if (expect_s == 2)      expect_s = 4;
      else if (expect_s == 3) expect_s = continuous ? 4 : 5;
      else                    expect_s = 0;

      if (hold_v && stb) begin
        chk("hold_adr", adr, hold_adr);
        chk("hold_dat", dat, hold_dat);
      end
      hold_v = 1'b0;

      if (stb && ack) begin
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL sb_underflow: unexpected beat adr %h dat %h", adr, dat);
        end else begin
          e = sb_q.pop_front();
          chk("beat_adr", adr, e[63:32]);
          chk("beat_dat", dat, e[31:0]);
        end
        ack_k++;
        if (ack_k == NPIX) begin
          expect_s = 3;
          ack_k    = 0;
        end else if (ack_k % BU == 0) begin
          expect_s = 2;
        end else begin
          expect_s = 1;
        end
      end else if (stb) begin
        hold_v   = 1'b1;
        hold_adr = adr;
        hold_dat = dat;
      end
    end
  end

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #2;
    chk("start_stb", 32'(stb), 32'd1);
    chk("start_adr", adr, BASE);
  endtask

  // Counts cycles from the first strobe cycle (1) to the frame_done cycle.
  task automatic wait_done(output int n);
    n = 1;
    while (!frame_done && n < 2000) begin
      @(negedge clk);
      #2;
      n++;
    end
    if (!frame_done) begin
      n_cmp++;
      n_fail++;
      $display("FAIL done_timeout: no frame_done after %0d cycles", n);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n;
  int pulses;
  initial begin
    rst_n       = 1'b0;
    start       = 1'b0;
    continuous  = 1'b0;
    pattern_sel = 2'd0;
    solid_rgb   = 24'h0;

    // Reset values, and start ignored while held in reset.
    @(negedge clk);
    #2;
    chk("rst_stb", 32'(stb), 32'd0);
    chk("rst_cyc", 32'(cyc), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(frame_done), 32'd0);
    chk("rst_we", 32'(we), 32'd1);
    chk("rst_sel", 32'(sel), 32'hF);
    chk("rst_cti_bte", {27'd0, cti, bte}, 32'd0);
    chk("rst_adr", adr, 32'd0);
    chk("rst_dat", dat, 32'd0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      start = (i == 3);
      #2;
      chk("rst_no_stb", 32'(stb), 32'd0);
    end
    @(negedge clk);
    start = 1'b0;
    rst_n = 1'b1;

    // Grid, ack tied high; DONE is the 72nd cycle counting the first strobe as 1.
    ack_mode = 0;
    pattern_sel = 2'd0;
    push_frame(0, 24'h0);
    do_start();
    wait_done(n);
    chk("grid_frame_len", 32'(n), 32'd72);
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #2;
      if (frame_done) pulses++;
    end
    chk("grid_done_once", 32'(pulses), 32'd0);
    chk("grid_sb_empty", 32'(sb_q.size()), 32'd0);

    // Colour bars with random ack latency.
    ack_mode = 2;
    pattern_sel = 2'd1;
    push_frame(1, 24'h0);
    do_start();
    wait_done(n);
    repeat (2) @(negedge clk);
    chk("bars_sb_empty", 32'(sb_q.size()), 32'd0);

    // Error on beat 0x114 forces a retry of that beat.
    ack_mode = 1;
    err_arm  = 1'b1;
    pattern_sel = 2'd0;
    push_frame(0, 24'h0);
    do_start();
    wait_done(n);
    repeat (2) @(negedge clk);
    chk("err_seen", 32'(err_arm), 32'd0);
    chk("err_sb_empty", 32'(sb_q.size()), 32'd0);

    // Continuous: solid frame, then gradient from the re-latched selector.
    ack_mode    = 1;
    pattern_sel = 2'd2;
    solid_rgb   = 24'h123456;
    continuous  = 1'b1;
    push_frame(2, 24'h123456);
    push_frame(3, 24'h0);
    do_start();
    repeat (20) @(negedge clk);
    pattern_sel = 2'd3;
    solid_rgb   = 24'hABCDEF;
    #2;
    wait_done(n);
    @(negedge clk);
    continuous = 1'b0;
    #2;
    chk("cont_second_stb", 32'(stb), 32'd1);
    chk("cont_second_busy", 32'(busy), 32'd1);
    wait_done(n);
    repeat (2) @(negedge clk);
    chk("cont_sb_empty", 32'(sb_q.size()), 32'd0);

    // Asynchronous reset while strobing 0x140, then a clean restart.
    ack_mode = 0;
    pattern_sel = 2'd0;
    push_frame(0, 24'h0);
    do_start();
    n = 0;
    while (!(stb && adr == 32'h140) && n < 200) begin
      @(negedge clk);
      #2;
      n++;
    end
    chk("reach_140", adr, 32'h140);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_stb", 32'(stb), 32'd0);
    chk("async_cyc", 32'(cyc), 32'd0);
    chk("async_busy", 32'(busy), 32'd0);
    sb_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    push_frame(0, 24'h0);
    do_start();
    wait_done(n);
    chk("restart_frame_len", 32'(n), 32'd72);
    repeat (2) @(negedge clk);
    chk("restart_sb_empty", 32'(sb_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
